cam_pwr_seq: RTL and testbench
==============================

# cam_pwr_seq

Camera power-up and configuration sequencer for the stereo capture path. It consumes `pll_locked`, `us_tck` and `ms_tck` from the clock-generation stage and drives each image sensor's power-down and reset pins with timed delays. It then triggers the sensor register-configuration engine, and retries or fails on configuration error or timeout. `cam_ready` gates the downstream capture logic.

## Interface
Parameters:
- `PWDN_MS`, default 10: ms ticks with power-down held after lock (≥1).
- `RST_US`, default 20: µs ticks with `cam_rst_n` held low (≥1).
- `SETTLE_MS`, default 5: ms ticks after reset release before configuration (≥1).
- `CFG_TO_MS`, default 500: ms ticks allowed for `cfg_done` (≥1).
- `MAX_RETRY`, default 3: failed configuration attempts before `seq_fail` (1–15).

Ports:
- `clk`  in  1  pixel clock (`pll_outclk_0`).
- `rst`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  PLL lock; level, synchronous to `clk`.
- `us_tck`  in  1  1-cycle pulse every µs.
- `ms_tck`  in  1  1-cycle pulse every ms.
- `cfg_done`  in  1  1-cycle pulse from the configuration engine on success.
- `cfg_err`  in  1  1-cycle pulse from the configuration engine on failure (I2C NACK).
- `cam_pwdn`  out  1  sensor power-down, active high.
- `cam_rst_n`  out  1  sensor reset, active low.
- `cfg_start`  out  1  1-cycle pulse that starts configuration.
- `cam_ready`  out  1  sensor configured; level.
- `seq_fail`  out  1  retries exhausted; sticky.
- `retry_cnt`  out  4  failed attempts so far.

## Operation
- All outputs are registered. Values while reset is asserted: `cam_pwdn`=1, `cam_rst_n`=0, `cfg_start`=0, `cam_ready`=0, `seq_fail`=0, `retry_cnt`=0, state IDLE.
- States and outputs:
  - IDLE: `cam_pwdn`=1, `cam_rst_n`=0.
  - PWDN: `cam_pwdn`=1, `cam_rst_n`=0.
  - RESET: `cam_pwdn`=0, `cam_rst_n`=0.
  - SETTLE: `cam_pwdn`=0, `cam_rst_n`=1.
  - CFG: `cam_pwdn`=0, `cam_rst_n`=1.
  - READY: same pins as CFG, plus `cam_ready`=1.
  - FAIL: `cam_pwdn`=1, `cam_rst_n`=0, `seq_fail`=1.
- State transitions:
  - IDLE→PWDN when `pll_locked`=1.
  - PWDN→RESET after `PWDN_MS` ms ticks.
  - RESET→SETTLE after `RST_US` µs ticks.
  - SETTLE→CFG after `SETTLE_MS` ms ticks.
  - CFG→READY on `cfg_done`.
  - CFG on `cfg_err` or after `CFG_TO_MS` ms ticks: `retry_cnt`+1, then →PWDN if the new count < `MAX_RETRY`, else →FAIL.
- Tick counting: the tick counter clears on every state entry. It counts only the tick type named for the current state. The state exits on the cycle the Nth tick is sampled, so the actual duration is between N−1 and N tick periods. Ticks sampled on the entry cycle are counted.
- `pll_locked` deasserted in any state except IDLE and FAIL: go to IDLE next cycle, with outputs at IDLE values. `retry_cnt` is preserved, so a lock loss is not counted as an attempt.
- FAIL is exited only by `rst`.
- `cfg_done` and `cfg_err` outside CFG are ignored.
- In CFG, precedence on the same cycle:
  - `cfg_err` wins over `cfg_done`.
  - `cfg_done` wins over a timeout tick.
- `retry_cnt` saturates at 15. It resets only on `rst`.

## Timing
- `pll_locked` rise → PWDN registered on the next edge. `cam_pwdn` is already 1, so no pin change occurs.
- SETTLE→CFG transition at edge k: `cfg_start`=1 during cycle k+1 only. It re-pulses on every retry entry into CFG.
- `cfg_done` sampled at edge k: `cam_ready`=1 from cycle k+1.
- `pll_locked` falling sampled at edge k: `cam_ready`=0, `cam_pwdn`=1 and `cam_rst_n`=0 from cycle k+1.
- Reset is asynchronous: outputs take their reset values immediately on `rst` falling, independent of `clk`. Release is by synchronous deassertion, performed externally.

## Structure
- Package `cam_seq_pkg`:
  - state encoding (7 states, 3 bits);
  - default timing constants;
  - `RETRY_W`=4.
- Sub-module `tick_timer`:
  - inputs `clk`, `rst`, `clr`, `tck`, `limit` (16-bit);
  - output `expire`, combinational, true when the count + `tck` reaches `limit`.
  - One instance serves all timed states; the FSM muxes `tck` and `limit` per state.

## Test plan
- Normal bring-up, `PWDN_MS`=2, `RST_US`=3, `SETTLE_MS`=1, with `pll_locked` raised at t0:
  - `cam_pwdn` falls after 2 ms ticks;
  - `cam_rst_n` rises after 3 µs ticks;
  - one `cfg_start` pulse after 1 ms tick;
  - `cfg_done` → `cam_ready`=1 next cycle.
- `cfg_err` three times with `MAX_RETRY`=3:
  - three `cfg_start` pulses, each preceded by a full PWDN/RESET/SETTLE cycle;
  - `retry_cnt` 1→2→3;
  - after the third error: FAIL, `seq_fail`=1, `cam_pwdn`=1.
- Timeout with `CFG_TO_MS`=4 and no response: after the 4th ms tick in CFG, `retry_cnt`=1 and state is PWDN.
- Same-cycle events in CFG:
  - `cfg_done` with `cfg_err` → retry, `cam_ready` stays 0;
  - `cfg_done` with the timeout tick → READY.
- `pll_locked` dropped in SETTLE, and separately in READY:
  - next cycle: IDLE, `cam_ready`=0, `cam_rst_n`=0;
  - relock restarts at PWDN with `retry_cnt` unchanged.
- `rst` asserted mid-RESET, between clock edges: outputs go to reset values immediately; after release, IDLE with `retry_cnt`=0.

Source files
------------

// File: rtl/cam_seq_pkg.sv
// Shared types and constants for the camera power-up sequencer.
// Holds the state encoding, default timings and the pin/retry helpers.
package cam_seq_pkg;

    localparam int RETRY_W = 4;
    localparam int TMR_W   = 16;

    localparam int DEF_PWDN_MS   = 10;
    localparam int DEF_RST_US    = 20;
    localparam int DEF_SETTLE_MS = 5;
    localparam int DEF_CFG_TO_MS = 500;
    localparam int DEF_MAX_RETRY = 3;

    localparam logic [RETRY_W-1:0] RETRY_SAT = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PWDN   = 3'd1,
        ST_RESET  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CFG    = 3'd4,
        ST_READY  = 3'd5,
        ST_FAIL   = 3'd6
    } cam_state_e;

    typedef struct packed {
        logic pwdn;
        logic rst_n;
        logic ready;
        logic fail;
    } cam_pins_t;

    // Saturating increment so a long fault history never wraps back to zero.
    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] cnt);
        logic [RETRY_W-1:0] res;
        if (cnt == RETRY_SAT) begin
            res = cnt;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

    // Sensor pin levels implied by a state; unknown encodings park the sensor safely off.
    function automatic cam_pins_t state_pins(input cam_state_e st);
        cam_pins_t p;
        p = '{pwdn: 1'b1, rst_n: 1'b0, ready: 1'b0, fail: 1'b0};
        case (st)
            ST_IDLE:   p = '{pwdn: 1'b1, rst_n: 1'b0, ready: 1'b0, fail: 1'b0};
            ST_PWDN:   p = '{pwdn: 1'b1, rst_n: 1'b0, ready: 1'b0, fail: 1'b0};
            ST_RESET:  p = '{pwdn: 1'b0, rst_n: 1'b0, ready: 1'b0, fail: 1'b0};
            ST_SETTLE: p = '{pwdn: 1'b0, rst_n: 1'b1, ready: 1'b0, fail: 1'b0};
            ST_CFG:    p = '{pwdn: 1'b0, rst_n: 1'b1, ready: 1'b0, fail: 1'b0};
            ST_READY:  p = '{pwdn: 1'b0, rst_n: 1'b1, ready: 1'b1, fail: 1'b0};
            ST_FAIL:   p = '{pwdn: 1'b1, rst_n: 1'b0, ready: 1'b0, fail: 1'b1};
            default:   p = '{pwdn: 1'b1, rst_n: 1'b0, ready: 1'b0, fail: 1'b0};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/cam_pwr_seq_tick_timer.sv
// Shared tick counter for all timed sequencer states.
// expire is combinational so the state can leave on the cycle the last tick arrives.
module tick_timer
    import cam_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             tck,
    input  logic [TMR_W-1:0] limit,
    output logic             expire
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;
    logic [TMR_W:0]   sum_s;

    // Count plus the tick sampled this cycle, compared against the limit.
    always_comb begin
        sum_s  = {1'b0, cnt_q} + {{TMR_W{1'b0}}, tck};
        expire = (sum_s >= {1'b0, limit});
        if (clr) begin
            cnt_d = {TMR_W{1'b0}};
        end else if (sum_s[TMR_W]) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = sum_s[TMR_W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {TMR_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cam_pwr_seq.sv
// Camera power-down / reset / configuration sequencer with bounded retries.
// Outputs are registered from the next state, so pins follow a transition by one edge.
module cam_pwr_seq
    import cam_seq_pkg::*;
#(
    parameter int PWDN_MS   = DEF_PWDN_MS,
    parameter int RST_US    = DEF_RST_US,
    parameter int SETTLE_MS = DEF_SETTLE_MS,
    parameter int CFG_TO_MS = DEF_CFG_TO_MS,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               us_tck,
    input  logic               ms_tck,
    input  logic               cfg_done,
    input  logic               cfg_err,
    output logic               cam_pwdn,
    output logic               cam_rst_n,
    output logic               cfg_start,
    output logic               cam_ready,
    output logic               seq_fail,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam logic [TMR_W-1:0]   PWDN_LIM   = TMR_W'(PWDN_MS);
    localparam logic [TMR_W-1:0]   RST_LIM    = TMR_W'(RST_US);
    localparam logic [TMR_W-1:0]   SETTLE_LIM = TMR_W'(SETTLE_MS);
    localparam logic [TMR_W-1:0]   CFG_TO_LIM = TMR_W'(CFG_TO_MS);
    localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);

    cam_state_e         state_q;
    cam_state_e         state_d;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_d;
    logic [RETRY_W-1:0] retry_next_s;

    logic               tmr_clr_s;
    logic               tmr_tck_s;
    logic [TMR_W-1:0]   tmr_limit_s;
    logic               tmr_expire_s;

    cam_pins_t          pins_d;
    logic               cam_pwdn_q;
    logic               cam_rst_n_q;
    logic               cfg_start_q;
    logic               cfg_start_d;
    logic               cam_ready_q;
    logic               seq_fail_q;

    tick_timer u_tick_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr_s),
        .tck    (tmr_tck_s),
        .limit  (tmr_limit_s),
        .expire (tmr_expire_s)
    );

    // Pick the tick source and length for the current timed state.
    always_comb begin
        tmr_tck_s   = 1'b0;
        tmr_limit_s = {TMR_W{1'b1}};
        case (state_q)
            ST_PWDN: begin
                tmr_tck_s   = ms_tck;
                tmr_limit_s = PWDN_LIM;
            end
            ST_RESET: begin
                tmr_tck_s   = us_tck;
                tmr_limit_s = RST_LIM;
            end
            ST_SETTLE: begin
                tmr_tck_s   = ms_tck;
                tmr_limit_s = SETTLE_LIM;
            end
            ST_CFG: begin
                tmr_tck_s   = ms_tck;
                tmr_limit_s = CFG_TO_LIM;
            end
            default: begin
                tmr_tck_s   = 1'b0;
                tmr_limit_s = {TMR_W{1'b1}};
            end
        endcase
    end

    // Next-state and retry logic; lock loss outranks every event except in IDLE/FAIL.
    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        retry_next_s = retry_inc(retry_q);
        if ((state_q != ST_IDLE) && (state_q != ST_FAIL) && !pll_locked) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pll_locked) begin
                        state_d = ST_PWDN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PWDN: begin
                    if (tmr_expire_s) begin
                        state_d = ST_RESET;
                    end else begin
                        state_d = ST_PWDN;
                    end
                end
                ST_RESET: begin
                    if (tmr_expire_s) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_RESET;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_expire_s) begin
                        state_d = ST_CFG;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
                ST_CFG: begin
                    // Error beats done, done beats the timeout tick.
                    if (cfg_err || (!cfg_done && tmr_expire_s)) begin
                        retry_d = retry_next_s;
                        if (retry_next_s < RETRY_LIM) begin
                            state_d = ST_PWDN;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end else if (cfg_done) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_CFG;
                    end
                end
                ST_READY: state_d = ST_READY;
                ST_FAIL:  state_d = ST_FAIL;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    assign tmr_clr_s = (state_d != state_q);

    // Output decode from the next state so the registered pins track the new state.
    always_comb begin
        pins_d      = state_pins(state_d);
        cfg_start_d = (state_d == ST_CFG) && (state_q != ST_CFG);
    end

    // State and retry registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            retry_q <= {RETRY_W{1'b0}};
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cam_pwdn_q  <= 1'b1;
            cam_rst_n_q <= 1'b0;
            cfg_start_q <= 1'b0;
            cam_ready_q <= 1'b0;
            seq_fail_q  <= 1'b0;
        end else begin
            cam_pwdn_q  <= pins_d.pwdn;
            cam_rst_n_q <= pins_d.rst_n;
            cfg_start_q <= cfg_start_d;
            cam_ready_q <= pins_d.ready;
            seq_fail_q  <= pins_d.fail;
        end
    end

    assign cam_pwdn  = cam_pwdn_q;
    assign cam_rst_n = cam_rst_n_q;
    assign cfg_start = cfg_start_q;
    assign cam_ready = cam_ready_q;
    assign seq_fail  = seq_fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Self-checking bench for cam_pwr_seq: directed scenarios plus random traffic
// compared every cycle against a phase/tick-count reference model.
module tb_cam_pwr_seq;

    localparam int P_PWDN = 2;
    localparam int P_RST  = 3;
    localparam int P_SET  = 1;
    localparam int P_TO   = 4;
    localparam int P_MAXR = 3;

    localparam int PH_IDLE = 0, PH_PWDN = 1, PH_RESET = 2, PH_SETTLE = 3;
    localparam int PH_CFG = 4, PH_READY = 5, PH_FAIL = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       us_tck = 1'b0;
    logic       ms_tck = 1'b0;
    logic       cfg_done = 1'b0;
    logic       cfg_err = 1'b0;
    logic       cam_pwdn, cam_rst_n, cfg_start, cam_ready, seq_fail;
    logic [3:0] retry_cnt;

    int n_checks = 0;
    int n_err = 0;

    int m_phase = PH_IDLE;
    int m_ticks = 0;
    int m_retries = 0;
    int m_start = 0;

    always #5 clk = ~clk;

    cam_pwr_seq #(
        .PWDN_MS(P_PWDN), .RST_US(P_RST), .SETTLE_MS(P_SET),
        .CFG_TO_MS(P_TO), .MAX_RETRY(P_MAXR)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .us_tck(us_tck),
        .ms_tck(ms_tck), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n), .cfg_start(cfg_start),
        .cam_ready(cam_ready), .seq_fail(seq_fail), .retry_cnt(retry_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_ticks = 0;
        m_retries = 0;
        m_start = 0;
    endtask

    task automatic model_goto(input int ph);
        m_phase = ph;
        m_ticks = 0;
    endtask

    task automatic model_attempt_failed();
        m_retries = (m_retries >= 15) ? 15 : m_retries + 1;
        model_goto((m_retries < P_MAXR) ? PH_PWDN : PH_FAIL);
    endtask

    // Advance the reference by one clock using the inputs present at the edge.
    task automatic model_step();
        int prev;
        prev = m_phase;
        if (m_phase != PH_IDLE && m_phase != PH_FAIL && !pll_locked) begin
            model_goto(PH_IDLE);
        end else begin
            case (m_phase)
                PH_IDLE: if (pll_locked) model_goto(PH_PWDN);
                PH_PWDN: if (ms_tck) begin
                    m_ticks++;
                    if (m_ticks == P_PWDN) model_goto(PH_RESET);
                end
                PH_RESET: if (us_tck) begin
                    m_ticks++;
                    if (m_ticks == P_RST) model_goto(PH_SETTLE);
                end
                PH_SETTLE: if (ms_tck) begin
                    m_ticks++;
                    if (m_ticks == P_SET) model_goto(PH_CFG);
                end
                PH_CFG: begin
                    if (cfg_err) model_attempt_failed();
                    else if (cfg_done) model_goto(PH_READY);
                    else if (ms_tck) begin
                        m_ticks++;
                        if (m_ticks == P_TO) model_attempt_failed();
                    end
                end
                default: ;
            endcase
        end
        m_start = (m_phase == PH_CFG && prev != PH_CFG) ? 1 : 0;
    endtask

    task automatic compare_all();
        int exp_pwdn, exp_rstn;
        exp_pwdn = (m_phase == PH_IDLE || m_phase == PH_PWDN || m_phase == PH_FAIL) ? 1 : 0;
        exp_rstn = (m_phase == PH_SETTLE || m_phase == PH_CFG || m_phase == PH_READY) ? 1 : 0;
        check("cam_pwdn", int'(cam_pwdn), exp_pwdn);
        check("cam_rst_n", int'(cam_rst_n), exp_rstn);
        check("cfg_start", int'(cfg_start), m_start);
        check("cam_ready", int'(cam_ready), (m_phase == PH_READY) ? 1 : 0);
        check("seq_fail", int'(seq_fail), (m_phase == PH_FAIL) ? 1 : 0);
        check("retry_cnt", int'(retry_cnt), m_retries);
    endtask

    task automatic step(input logic l, input logic u, input logic m, input logic d, input logic e);
        pll_locked = l; us_tck = u; ms_tck = m; cfg_done = d; cfg_err = e;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pwdn"}, int'(cam_pwdn), 1);
        check({tag, "_rst_n"}, int'(cam_rst_n), 0);
        check({tag, "_cfg_start"}, int'(cfg_start), 0);
        check({tag, "_ready"}, int'(cam_ready), 0);
        check({tag, "_fail"}, int'(seq_fail), 0);
        check({tag, "_retry"}, int'(retry_cnt), 0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // From PWDN entry, walk PWDN/RESET/SETTLE with idle gaps between ticks up to CFG entry.
    task automatic bringup();
        for (int i = 0; i < P_PWDN; i++) begin step(1, 0, 0, 0, 0); step(1, 0, 1, 0, 0); end
        for (int i = 0; i < P_RST; i++) begin step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); end
        for (int i = 0; i < P_SET; i++) begin step(1, 0, 0, 0, 0); step(1, 0, 1, 0, 0); end
        check("bringup_cfg_start", int'(cfg_start), 1);
    endtask

    initial begin
        int fail_cycles;
        #12;
        check_reset_values("por");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Normal bring-up with literal pin checks along the way.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        check("lock_pwdn_hi", int'(cam_pwdn), 1);
        step(1, 0, 1, 0, 0);
        check("pwdn_after_1ms", int'(cam_pwdn), 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        check("pwdn_after_2ms", int'(cam_pwdn), 0);
        check("rst_n_in_reset", int'(cam_rst_n), 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        check("rst_n_after_2us", int'(cam_rst_n), 0);
        step(1, 1, 0, 0, 0);
        check("rst_n_after_3us", int'(cam_rst_n), 1);
        check("no_start_in_settle", int'(cfg_start), 0);
        step(1, 0, 1, 0, 0);
        check("cfg_start_pulse", int'(cfg_start), 1);
        step(1, 0, 0, 0, 0);
        check("cfg_start_single", int'(cfg_start), 0);
        step(1, 0, 0, 1, 0);
        check("ready_after_done", int'(cam_ready), 1);

        // Lock loss in READY, then three configuration errors into FAIL.
        step(0, 0, 0, 0, 0);
        check("ready_drop", int'(cam_ready), 0);
        check("ready_drop_rst_n", int'(cam_rst_n), 0);
        step(1, 0, 0, 0, 0);
        check("relock_retry", int'(retry_cnt), 0);
        for (int k = 1; k <= 3; k++) begin
            bringup();
            step(1, 0, 0, 0, 1);
            check("err_retry", int'(retry_cnt), k);
        end
        check("fail_seq_fail", int'(seq_fail), 1);
        check("fail_pwdn", int'(cam_pwdn), 1);
        check("model_fail_pin", m_phase, PH_FAIL);
        step(0, 0, 1, 0, 0);
        step(1, 1, 1, 1, 1);
        check("fail_sticky", int'(seq_fail), 1);
        apply_reset("fail_exit");

        // CFG timeout after four ms ticks.
        step(1, 0, 0, 0, 0);
        bringup();
        for (int i = 0; i < P_TO - 1; i++) begin step(1, 0, 1, 0, 0); step(1, 0, 0, 0, 0); end
        check("to_not_yet", int'(cam_rst_n), 1);
        step(1, 0, 1, 0, 0);
        check("to_retry", int'(retry_cnt), 1);
        check("to_pwdn", int'(cam_pwdn), 1);

        // Same-cycle precedence in CFG.
        bringup();
        step(1, 0, 0, 1, 1);
        check("done_err_retry", int'(retry_cnt), 2);
        check("done_err_ready", int'(cam_ready), 0);
        bringup();
        for (int i = 0; i < P_TO - 1; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 0);
        check("done_to_ready", int'(cam_ready), 1);
        check("done_to_retry", int'(retry_cnt), 2);

        // Lock loss in SETTLE.
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < P_PWDN; i++) step(1, 0, 1, 0, 0);
        for (int i = 0; i < P_RST; i++) step(1, 1, 0, 0, 0);
        check("in_settle", int'(cam_rst_n), 1);
        step(0, 0, 0, 0, 0);
        check("settle_drop_rst_n", int'(cam_rst_n), 0);
        check("settle_drop_pwdn", int'(cam_pwdn), 1);
        step(1, 0, 0, 0, 0);
        check("settle_relock_retry", int'(retry_cnt), 2);

        // Asynchronous reset while in RESET.
        for (int i = 0; i < P_PWDN; i++) step(1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        check("mid_reset_pwdn", int'(cam_pwdn), 0);
        apply_reset("async");
        step(0, 0, 0, 0, 0);
        check("post_reset_retry", int'(retry_cnt), 0);

        // Random traffic against the model.
        fail_cycles = 0;
        for (int c = 0; c < 4000; c++) begin
            step(($urandom_range(0, 149) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
            fail_cycles = (m_phase == PH_FAIL) ? fail_cycles + 1 : 0;
            if (fail_cycles > 30 || (m_phase == PH_READY && $urandom_range(0, 99) == 0)) begin
                apply_reset("rand");
                fail_cycles = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
